// File: rtl/rof_sample_sequencer.sv
// Sample sequencer for the rank-order filter demo: walks a sample ROM on clk, strobes each
// sample into the filter and captures its result. Optional macro ROF_SEQ_STOP_AT_END_EN.
module rof_sample_sequencer #(
    parameter int DATA_BITS = 8,
    parameter int ADDR_BITS = 8,
    parameter int ROM_DEPTH = 256,
    parameter int FILT_LAT  = 1,
    parameter int RUN_DIV   = 50000000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 btn_step,
    input  logic                 btn_mode,
    input  logic [DATA_BITS-1:0] rom_data,
    input  logic [DATA_BITS-1:0] filt_out,
    output logic [ADDR_BITS-1:0] rom_addr,
    output logic                 sample_en,
    output logic [DATA_BITS-1:0] sample_data,
    output logic [DATA_BITS-1:0] disp_in,
    output logic [DATA_BITS-1:0] disp_out,
    output logic                 running,
    output logic                 wrapped
);

    localparam int LAT_W = $clog2(FILT_LAT + 1);
    localparam int PS_W  = $clog2(RUN_DIV);

    localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(ROM_DEPTH - 1);
    localparam logic [LAT_W-1:0]     LAT_LOAD  = LAT_W'(FILT_LAT);
    localparam logic [PS_W-1:0]      PS_LAST   = PS_W'(RUN_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_ISSUE = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [2:0]           r_step_sync;
    logic [2:0]           r_mode_sync;
    logic [PS_W-1:0]      r_presc;
    logic                 r_pend;
    logic                 r_running;
    logic                 r_wrapped;
    logic [ADDR_BITS-1:0] r_addr;
    logic [LAT_W-1:0]     r_lat;
    logic                 r_sample_en;
    logic [DATA_BITS-1:0] r_sample_data;
    logic [DATA_BITS-1:0] r_disp_in;
    logic [DATA_BITS-1:0] r_disp_out;

    logic w_step_press;
    logic w_mode_press;
    logic w_tick;
    logic w_issue;
    logic w_capture;
    logic w_leave_idle;
    logic w_stop;

    // Two synchronizer flops, the third holds the previous level for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_step_sync <= '0;
            r_mode_sync <= '0;
        end else begin
            r_step_sync <= {r_step_sync[1:0], btn_step};
            r_mode_sync <= {r_mode_sync[1:0], btn_mode};
        end
    end

    assign w_step_press = r_step_sync[1] & ~r_step_sync[2];
    assign w_mode_press = r_mode_sync[1] & ~r_mode_sync[2];
    assign w_tick       = r_running && (r_presc == PS_LAST);

`ifdef ROF_SEQ_STOP_AT_END_EN
    assign w_stop = w_issue && r_running && (r_addr == LAST_ADDR);
`else
    assign w_stop = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_issue      = 1'b0;
        w_capture    = 1'b0;
        w_leave_idle = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_running ? (w_tick || r_pend) : w_step_press) begin
                    w_state_nxt  = S_FETCH;
                    w_leave_idle = 1'b1;
                end
            end
            S_FETCH: w_state_nxt = S_ISSUE;
            S_ISSUE: begin
                w_issue     = 1'b1;
                w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (r_lat == '0) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Mode toggling, prescaler and the single-slot pending RUN tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_running <= 1'b0;
            r_presc   <= '0;
            r_pend    <= 1'b0;
        end else begin
            if (w_stop) begin
                r_running <= 1'b0;
            end else if (w_mode_press) begin
                r_running <= ~r_running;
            end

            if (w_mode_press) begin
                r_presc <= '0;
            end else if (r_running) begin
                r_presc <= (r_presc == PS_LAST) ? '0 : r_presc + PS_W'(1);
            end

            if (!r_running || w_mode_press) begin
                r_pend <= 1'b0;
            end else if (w_tick && r_state != S_IDLE) begin
                r_pend <= 1'b1;
            end else if (w_leave_idle) begin
                r_pend <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sample_en   <= 1'b0;
            r_sample_data <= '0;
            r_disp_in     <= '0;
            r_disp_out    <= '0;
            r_addr        <= '0;
            r_wrapped     <= 1'b0;
            r_lat         <= '0;
        end else begin
            r_sample_en <= w_issue;
            if (w_issue) begin
                r_sample_data <= rom_data;
                r_disp_in     <= rom_data;
                r_lat         <= LAT_LOAD;
                if (r_addr == LAST_ADDR) begin
                    r_addr    <= '0;
                    r_wrapped <= 1'b1;
                end else begin
                    r_addr <= r_addr + ADDR_BITS'(1);
                end
            end else if (r_state == S_DRAIN && r_lat != '0) begin
                r_lat <= r_lat - LAT_W'(1);
            end
            if (w_capture) begin
                r_disp_out <= filt_out;
            end
        end
    end

    assign rom_addr    = r_addr;
    assign sample_en   = r_sample_en;
    assign sample_data = r_sample_data;
    assign disp_in     = r_disp_in;
    assign disp_out    = r_disp_out;
    assign running     = r_running;
    assign wrapped     = r_wrapped;

endmodule

// File: tb/tb_rof_sample_sequencer.sv
// Directed bench for rof_sample_sequencer: two instances (FILT_LAT=1 / ROM_DEPTH=4 and
// FILT_LAT=4), ROM and filter models, and a sample scoreboard per instance.
module tb_rof_sample_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    // Instance A: ROM_DEPTH=4, FILT_LAT=1, RUN_DIV=8
    logic       rst_a, a_step, a_mode, a_en, a_run, a_wrap;
    logic [7:0] a_rom, a_filt, a_addr, a_data, a_din, a_dout;

    rof_sample_sequencer #(
        .DATA_BITS(8), .ADDR_BITS(8), .ROM_DEPTH(4), .FILT_LAT(1), .RUN_DIV(8)
    ) u_dut_a (
        .clk(clk), .rst(rst_a), .btn_step(a_step), .btn_mode(a_mode),
        .rom_data(a_rom), .filt_out(a_filt), .rom_addr(a_addr), .sample_en(a_en),
        .sample_data(a_data), .disp_in(a_din), .disp_out(a_dout),
        .running(a_run), .wrapped(a_wrap)
    );

    // Instance B: ROM_DEPTH=256, FILT_LAT=4, RUN_DIV=8
    logic       rst_b, b_step, b_mode, b_en, b_run, b_wrap;
    logic [7:0] b_rom, b_filt, b_addr, b_data, b_din, b_dout;

    rof_sample_sequencer #(
        .DATA_BITS(8), .ADDR_BITS(8), .ROM_DEPTH(256), .FILT_LAT(4), .RUN_DIV(8)
    ) u_dut_b (
        .clk(clk), .rst(rst_b), .btn_step(b_step), .btn_mode(b_mode),
        .rom_data(b_rom), .filt_out(b_filt), .rom_addr(b_addr), .sample_en(b_en),
        .sample_data(b_data), .disp_in(b_din), .disp_out(b_dout),
        .running(b_run), .wrapped(b_wrap)
    );

    // ROM[i] = i + 16 with one clock of read latency; filters pass the sample through.
    logic [7:0] b_st [4] = '{default: 8'h00};
    always @(posedge clk) begin
        a_rom <= a_addr + 8'h10;
        b_rom <= b_addr + 8'h10;
        if (a_en) a_filt <= a_data;
        b_st[0] <= b_en ? b_data : b_st[0];
        b_st[1] <= b_st[0];
        b_st[2] <= b_st[1];
        b_st[3] <= b_st[2];
    end
    assign b_filt = b_st[3];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Scoreboards: expected sample values queued at stimulus time, popped on sample_en.
    logic [7:0] qa[$];
    logic [7:0] qb[$];
    int         ta[$];
    int         na = 0, nb = 0;
    logic       a_prev = 1'b0, b_prev = 1'b0;
    logic [8:0] e_a, e_b;

    always @(negedge clk) begin
        if (a_en) begin
            na++;
            ta.push_back(cyc);
            chk("a_back_to_back", 32'(a_prev), 32'd0);
            e_a = (qa.size() > 0) ? {1'b0, qa.pop_front()} : 9'h1ff;
            chk("a_sample_data", 32'({1'b0, a_data}), 32'(e_a));
        end
        if (b_en) begin
            nb++;
            chk("b_back_to_back", 32'(b_prev), 32'd0);
            e_b = (qb.size() > 0) ? {1'b0, qb.pop_front()} : 9'h1ff;
            chk("b_sample_data", 32'({1'b0, b_data}), 32'(e_b));
        end
        a_prev = a_en;
        b_prev = b_en;
    end

    task automatic step_cycle();
        @(negedge clk);
        #1;
    endtask

    task automatic chk_zero_a(input string tag);
        chk({tag, "_addr"}, 32'(a_addr), 32'd0);
        chk({tag, "_en"},   32'(a_en),   32'd0);
        chk({tag, "_data"}, 32'(a_data), 32'd0);
        chk({tag, "_din"},  32'(a_din),  32'd0);
        chk({tag, "_dout"}, 32'(a_dout), 32'd0);
        chk({tag, "_run"},  32'(a_run),  32'd0);
        chk({tag, "_wrap"}, 32'(a_wrap), 32'd0);
    endtask

    task automatic chk_zero_b(input string tag);
        chk({tag, "_addr"}, 32'(b_addr), 32'd0);
        chk({tag, "_en"},   32'(b_en),   32'd0);
        chk({tag, "_data"}, 32'(b_data), 32'd0);
        chk({tag, "_din"},  32'(b_din),  32'd0);
        chk({tag, "_dout"}, 32'(b_dout), 32'd0);
        chk({tag, "_run"},  32'(b_run),  32'd0);
        chk({tag, "_wrap"}, 32'(b_wrap), 32'd0);
    endtask

    task automatic wait_na(input int n, input int bound, input string tag);
        int k = 0;
        while (na < n && k < bound) begin
            step_cycle();
            k++;
        end
        chk(tag, 32'(na >= n), 32'd1);
    endtask

    task automatic wait_nb(input int n, input int bound, input string tag);
        int k = 0;
        while (nb < n && k < bound) begin
            step_cycle();
            k++;
        end
        chk(tag, 32'(nb >= n), 32'd1);
    endtask

    int t0;
    int k;
    int base;

    initial begin
        rst_a = 1'b1; a_step = 1'b0; a_mode = 1'b0;
        rst_b = 1'b1; b_step = 1'b0; b_mode = 1'b0;
        repeat (3) step_cycle();
        chk_zero_a("a_reset");
        rst_a = 1'b0;
        repeat (3) step_cycle();

        // Single step press: latency 3 sync + FETCH + ISSUE + FILT_LAT after the first sampling edge.
        qa.push_back(8'h10);
        a_step = 1'b1;
        t0 = cyc;
        k = 0;
        while (a_dout !== 8'h10 && k < 40) begin step_cycle(); k++; end
        chk("a_step_latency", 32'(cyc - t0), 32'd7);
        chk("a_step_addr", 32'(a_addr), 32'd1);
        chk("a_step_din", 32'(a_din), 32'h10);
        chk("a_step_count", 32'(na), 32'd1);
        a_step = 1'b0;
        repeat (17) step_cycle();

        // Three presses 20 clocks apart; the last one wraps the 4-word ROM.
        for (int i = 0; i < 3; i++) begin
            qa.push_back(8'(8'h11 + i));
            a_step = 1'b1;
            repeat (3) step_cycle();
            a_step = 1'b0;
            repeat (17) step_cycle();
        end
        chk("a_three_count", 32'(na), 32'd4);
        chk("a_three_addr", 32'(a_addr), 32'd0);
        chk("a_three_wrap", 32'(a_wrap), 32'd1);
        chk("a_three_din", 32'(a_din), 32'h13);
        chk("a_three_dout", 32'(a_dout), 32'h13);

        rst_a = 1'b1;
        step_cycle();
        chk_zero_a("a_reset2");
        rst_a = 1'b0;
        repeat (2) step_cycle();

        // RUN mode with RUN_DIV=8.
        base = na;
        ta.delete();
        qa.push_back(8'h10); qa.push_back(8'h11); qa.push_back(8'h12); qa.push_back(8'h13);
`ifndef ROF_SEQ_STOP_AT_END_EN
        qa.push_back(8'h10);
`endif
        a_mode = 1'b1;
        repeat (2) step_cycle();
        a_mode = 1'b0;
        wait_na(base + 1, 40, "a_run_first");
        chk("a_run_on", 32'(a_run), 32'd1);
        a_step = 1'b1;
        repeat (3) step_cycle();
        a_step = 1'b0;
        wait_na(base + 3, 60, "a_run_third");
        chk("a_run_wrap_before", 32'(a_wrap), 32'd0);
        wait_na(base + 4, 20, "a_run_fourth");
        chk("a_run_wrap_after", 32'(a_wrap), 32'd1);
`ifdef ROF_SEQ_STOP_AT_END_EN
        chk("a_stop_run_cleared", 32'(a_run), 32'd0);
        repeat (40) step_cycle();
        chk("a_stop_count", 32'(na), 32'(base + 4));
        chk("a_stop_addr", 32'(a_addr), 32'd0);
        chk("a_stop_run", 32'(a_run), 32'd0);
        chk("a_stop_dout", 32'(a_dout), 32'h13);
`else
        chk("a_run_still_on", 32'(a_run), 32'd1);
        wait_na(base + 5, 20, "a_run_fifth");
        a_mode = 1'b1;
        repeat (2) step_cycle();
        a_mode = 1'b0;
        repeat (40) step_cycle();
        chk("a_runoff_count", 32'(na), 32'(base + 5));
        chk("a_runoff_run", 32'(a_run), 32'd0);
        chk("a_runoff_dout", 32'(a_dout), 32'h10);
        chk("a_runoff_addr", 32'(a_addr), 32'd1);
`endif
        for (int i = 1; i < ta.size(); i++) begin
            chk("a_run_gap", 32'(ta[i] - ta[i-1]), 32'd8);
        end

        // Instance B: FILT_LAT=4, a press during DRAIN is dropped.
        rst_b = 1'b0;
        repeat (3) step_cycle();
        qb.push_back(8'h10);
        b_step = 1'b1;
        t0 = cyc;
        repeat (2) step_cycle();
        b_step = 1'b0;
        wait_nb(1, 20, "b_first_issue");
        b_step = 1'b1;
        step_cycle();
        b_step = 1'b0;
        k = 0;
        while (b_dout !== 8'h10 && k < 30) begin step_cycle(); k++; end
        chk("b_latency", 32'(cyc - t0), 32'd10);
        repeat (20) step_cycle();
        chk("b_drop_count", 32'(nb), 32'd1);
        chk("b_drop_addr", 32'(b_addr), 32'd1);
        chk("b_drop_din", 32'(b_din), 32'h10);

        // Reset asserted in DRAIN: outputs clear at once and no capture follows.
        qb.push_back(8'h11);
        b_step = 1'b1;
        repeat (2) step_cycle();
        b_step = 1'b0;
        wait_nb(2, 20, "b_second_issue");
        step_cycle();
        rst_b = 1'b1;
        #1;
        chk_zero_b("b_async_rst");
        step_cycle();
        rst_b = 1'b0;
        repeat (20) step_cycle();
        chk("b_no_capture", 32'(b_dout), 32'd0);
        chk("b_post_rst_addr", 32'(b_addr), 32'd0);
        chk("b_post_rst_count", 32'(nb), 32'd2);

        qb.push_back(8'h10);
        b_step = 1'b1;
        repeat (2) step_cycle();
        b_step = 1'b0;
        k = 0;
        while (b_dout !== 8'h10 && k < 30) begin step_cycle(); k++; end
        chk("b_reissue_dout", 32'(b_dout), 32'h10);
        chk("b_reissue_addr", 32'(b_addr), 32'd1);
        chk("b_reissue_count", 32'(nb), 32'd3);

        chk("a_queue_empty", 32'(qa.size()), 32'd0);
        chk("b_queue_empty", 32'(qb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
